mbus_ext_int_seq: RTL
=====================

# mbus_ext_int_seq

Clocked sequencer directly downstream of the external-interrupt latch. It consumes the latched `EXTERNAL_INT_TO_BUS` level and, if needed, wakes the bus controller (BC). It then waits for an idle bus, requests arbitration with bounded retries, and returns the one-cycle `CLR_EXT_INT` pulse that clears the latch. It sits between the interrupt latch and the BC arbitration logic in the bus-clock domain.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles spent in WAKE waiting for BC power release.
- `HOLDOFF_CYCLES`, 4: back-off cycles after a lost arbitration (≥1).
- `MAX_RETRY`, 3: lost arbitrations tolerated before error (≤15).
- `CLK`  in  1  bus clock; all state on rising edge.
- `RESETn_local`  in  1  reset, asynchronous, active-low.
- `EXTERNAL_INT_TO_BUS`  in  1  asynchronous level from the interrupt latch.
- `BUS_BUSYn`  in  1  asynchronous, low = bus busy.
- `BC_PWR_ON`  in  1  BC power state; compared against `IO_RELEASE` (BC awake).
- `ARB_GRANT`  in  1  synchronous, arbitration won.
- `ARB_LOST`  in  1  synchronous, arbitration lost.
- `BC_WAKE_REQ`  out  1  request BC power-up.
- `ARB_REQ`  out  1  request bus arbitration.
- `CLR_EXT_INT`  out  1  one-cycle pulse clearing the latch.
- `INT_TIMEOUT`  out  1  sticky error flag.
- `RETRY_CNT`  out  4  lost-arbitration count for the current request.

## Operation
- `EXTERNAL_INT_TO_BUS` and `BUS_BUSYn` each pass through a 2-flop synchronizer, giving `int_s` and `idle_s`. `BC_PWR_ON` is treated as quasi-static and is sampled directly.
- States and transitions:
  - **IDLE**: when `int_s` = 1:
    - clear `RETRY_CNT` and the timer;
    - go to WAIT_IDLE if `BC_PWR_ON` = `IO_RELEASE`, else go to WAKE.
  - **WAKE**: `BC_WAKE_REQ` = 1; the timer increments each cycle.
    - `BC_PWR_ON` = `IO_RELEASE` → WAIT_IDLE.
    - Timer reaches `TIMEOUT_CYCLES` → ERROR.
  - **WAIT_IDLE**: `idle_s` = 1 → ARB.
  - **ARB**: `ARB_REQ` = 1.
    - `ARB_GRANT` → CLEAR.
    - `ARB_LOST` with `RETRY_CNT` < `MAX_RETRY` → HOLDOFF, and `RETRY_CNT` increments.
    - `ARB_LOST` with `RETRY_CNT` = `MAX_RETRY` → ERROR.
    - `ARB_GRANT` and `ARB_LOST` in the same cycle: grant wins.
  - **HOLDOFF**: timer counts `HOLDOFF_CYCLES`, then → WAIT_IDLE.
  - **ERROR**: set `INT_TIMEOUT` (cleared only by reset), then → CLEAR.
  - **CLEAR**: `CLR_EXT_INT` = 1 for exactly one cycle, then → DONE.
  - **DONE**: wait for `int_s` = 0, then → IDLE. This prevents re-triggering on a stale synchronized level.
- Abort: `int_s` falling in WAKE, WAIT_IDLE or HOLDOFF → IDLE, with no `CLR_EXT_INT`. ARB is not aborted; it always completes via grant or lost.
- Outputs are decoded from the state register; no combinational path runs from inputs to outputs.
- Timer width is `$clog2(max(TIMEOUT_CYCLES, HOLDOFF_CYCLES)+1)`. The timer reloads to 0 on every state change.

## Timing
- Reset values: state IDLE, all outputs 0, `RETRY_CNT` = 0, synchronizers 0.
- Reset asserted mid-sequence returns to IDLE immediately. Any request in progress is dropped without `CLR_EXT_INT`; the latch keeps its level and is serviced again after reset.
- Best-case latency: `EXTERNAL_INT_TO_BUS` rises before edge 0, BC awake, bus idle:
  - `int_s` high after edge 1;
  - WAIT_IDLE after edge 2;
  - `ARB_REQ` high after edge 3.
- `ARB_GRANT` sampled at edge k gives `CLR_EXT_INT` high from edge k+1 to edge k+2.
- From WAKE, `BC_PWR_ON` sampled released at edge k gives WAIT_IDLE after edge k.
- WAKE timeout: ERROR is entered exactly `TIMEOUT_CYCLES` cycles after entering WAKE, and `CLR_EXT_INT` pulses 2 cycles after that.
- HOLDOFF lasts exactly `HOLDOFF_CYCLES` cycles.

## Structure
- State encodings belong in the shared `mbus_def.v` include, as `` `MBUS_EIS_IDLE ``…`` `MBUS_EIS_DONE `` (3 bits). `IO_RELEASE`/`IO_HOLD` come from that same include.
- One sub-module, `mbus_sync2`: a 2-flop synchronizer with async active-low reset, instantiated twice.
- The FSM, timer and retry counter live in the top module.

## Test plan
- BC awake, bus idle: raise `EXTERNAL_INT_TO_BUS`, grant on the first `ARB_REQ` cycle → `ARB_REQ` at edge 3, one `CLR_EXT_INT` pulse, `RETRY_CNT` = 0, `INT_TIMEOUT` = 0.
- BC asleep: `BC_PWR_ON` released 10 cycles after `BC_WAKE_REQ` → `BC_WAKE_REQ` high for 10 cycles, then the normal grant path. Repeat with no release and `TIMEOUT_CYCLES` = 20 → ERROR after 20 cycles, `INT_TIMEOUT` = 1, one `CLR_EXT_INT` pulse.
- Arbitration: `ARB_LOST` on attempts 1–3, grant on attempt 4 → three 4-cycle holdoffs, `RETRY_CNT` = 3, then CLEAR. Four losses → ERROR with `RETRY_CNT` = 3.
- `BUS_BUSYn` held low 50 cycles → `ARB_REQ` stays low until 2 cycles after `BUS_BUSYn` rises. `ARB_GRANT` and `ARB_LOST` asserted together → CLEAR path taken, `RETRY_CNT` unchanged.
- Abort and DONE hold: `EXTERNAL_INT_TO_BUS` drops while in WAKE → IDLE, no `CLR_EXT_INT`. After CLEAR with the input held high, FSM stays in DONE and issues no second pulse.
- Reset mid-ARB → all outputs 0 asynchronously. After release with the input still high → a fresh request with `RETRY_CNT` = 0.

Source files
------------

// File: rtl/mbus_ext_int_seq_pkg.sv
// Shared definitions for the external-interrupt sequencer: state
// encodings, BC power-state polarity and a small constant helper.
package mbus_ext_int_seq_pkg;

    // BC power control polarity: RELEASE means the BC is awake.
    localparam logic IO_RELEASE = 1'b0;
    localparam logic IO_HOLD    = 1'b1;

    // Sequencer state encodings (3 bits, legacy-compatible constants).
    localparam logic [2:0] MBUS_EIS_IDLE      = 3'd0;
    localparam logic [2:0] MBUS_EIS_WAKE      = 3'd1;
    localparam logic [2:0] MBUS_EIS_WAIT_IDLE = 3'd2;
    localparam logic [2:0] MBUS_EIS_ARB       = 3'd3;
    localparam logic [2:0] MBUS_EIS_HOLDOFF   = 3'd4;
    localparam logic [2:0] MBUS_EIS_ERROR     = 3'd5;
    localparam logic [2:0] MBUS_EIS_CLEAR     = 3'd6;
    localparam logic [2:0] MBUS_EIS_DONE      = 3'd7;

    // Larger of two integers; used to size the shared WAKE/HOLDOFF timer.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mbus_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the bus
// clock domain. Both flops clear to 0 on reset.
module mbus_sync2 (
    input  logic CLK,
    input  logic RESETn_local,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops.
    // NOTE: async active-low reset sits in the sensitivity list so the
    // flops clear without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RESETn_local) begin
        if (!RESETn_local) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make meta and q update together,
            // giving two real flop stages instead of collapsing into one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mbus_ext_int_seq.sv
// External-interrupt sequencer: takes the latched interrupt level, wakes
// the BC if needed, waits for an idle bus, arbitrates with bounded
// retries and returns a one-cycle CLR_EXT_INT pulse to clear the latch.
module mbus_ext_int_seq
    import mbus_ext_int_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int HOLDOFF_CYCLES = 4,
    parameter int MAX_RETRY      = 3
) (
    input  logic       CLK,
    input  logic       RESETn_local,
    input  logic       EXTERNAL_INT_TO_BUS,
    input  logic       BUS_BUSYn,
    input  logic       BC_PWR_ON,
    input  logic       ARB_GRANT,
    input  logic       ARB_LOST,
    output logic       BC_WAKE_REQ,
    output logic       ARB_REQ,
    output logic       CLR_EXT_INT,
    output logic       INT_TIMEOUT,
    output logic [3:0] RETRY_CNT
);

    localparam int TIMER_W = $clog2(max2(TIMEOUT_CYCLES, HOLDOFF_CYCLES) + 1);

    // Last timer value spent in a state before the timed exit fires; the
    // timer is 0 on the first cycle of a state, so N cycles end at N-1.
    localparam logic [TIMER_W-1:0] WAKE_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLDOFF_CYCLES - 1);
    localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRY);

    logic               int_s;
    logic               idle_s;
    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [TIMER_W-1:0] timer;
    logic               retry_clr;
    logic               retry_inc;
    logic               bc_awake;

    mbus_sync2 u_sync_int (
        .CLK          (CLK),
        .RESETn_local (RESETn_local),
        .d            (EXTERNAL_INT_TO_BUS),
        .q            (int_s)
    );

    mbus_sync2 u_sync_idle (
        .CLK          (CLK),
        .RESETn_local (RESETn_local),
        .d            (BUS_BUSYn),
        .q            (idle_s)
    );

    // BC power state is quasi-static, so it is used without synchronizing.
    assign bc_awake = (BC_PWR_ON == IO_RELEASE);

    // Next-state and counter-control decode.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_nxt = state;
        retry_clr = 1'b0;
        retry_inc = 1'b0;
        case (state)
            MBUS_EIS_IDLE: begin
                if (int_s) begin
                    retry_clr = 1'b1;
                    state_nxt = bc_awake ? MBUS_EIS_WAIT_IDLE : MBUS_EIS_WAKE;
                end
            end
            MBUS_EIS_WAKE: begin
                if (!int_s)
                    state_nxt = MBUS_EIS_IDLE;
                else if (bc_awake)
                    state_nxt = MBUS_EIS_WAIT_IDLE;
                else if (timer == WAKE_LAST)
                    state_nxt = MBUS_EIS_ERROR;
            end
            MBUS_EIS_WAIT_IDLE: begin
                if (!int_s)
                    state_nxt = MBUS_EIS_IDLE;
                else if (idle_s)
                    state_nxt = MBUS_EIS_ARB;
            end
            MBUS_EIS_ARB: begin
                // Not abortable: the arbiter always resolves with grant or
                // lost, and grant takes priority if both arrive together.
                if (ARB_GRANT) begin
                    state_nxt = MBUS_EIS_CLEAR;
                end else if (ARB_LOST) begin
                    if (RETRY_CNT >= RETRY_MAX) begin
                        state_nxt = MBUS_EIS_ERROR;
                    end else begin
                        state_nxt = MBUS_EIS_HOLDOFF;
                        retry_inc = 1'b1;
                    end
                end
            end
            MBUS_EIS_HOLDOFF: begin
                if (!int_s)
                    state_nxt = MBUS_EIS_IDLE;
                else if (timer == HOLD_LAST)
                    state_nxt = MBUS_EIS_WAIT_IDLE;
            end
            MBUS_EIS_ERROR: state_nxt = MBUS_EIS_CLEAR;
            MBUS_EIS_CLEAR: state_nxt = MBUS_EIS_DONE;
            MBUS_EIS_DONE: begin
                // Wait for the cleared latch to propagate through the
                // synchronizer so the stale level cannot re-trigger.
                if (!int_s)
                    state_nxt = MBUS_EIS_IDLE;
            end
            default: state_nxt = MBUS_EIS_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge RESETn_local) begin
        if (!RESETn_local)
            state <= MBUS_EIS_IDLE;
        else
            state <= state_nxt;
    end

    // Shared timer: restarts at 0 on every state change, counts in WAKE
    // and HOLDOFF only.
    always_ff @(posedge CLK or negedge RESETn_local) begin
        if (!RESETn_local)
            timer <= '0;
        else if (state_nxt != state)
            timer <= '0;
        else if (state == MBUS_EIS_WAKE || state == MBUS_EIS_HOLDOFF)
            timer <= timer + TIMER_W'(1);
    end

    // Lost-arbitration counter for the request in progress.
    always_ff @(posedge CLK or negedge RESETn_local) begin
        if (!RESETn_local)
            RETRY_CNT <= 4'd0;
        else if (retry_clr)
            RETRY_CNT <= 4'd0;
        else if (retry_inc)
            RETRY_CNT <= RETRY_CNT + 4'd1;
    end

    // Registered clear pulse (one cycle behind CLEAR) and sticky error flag.
    always_ff @(posedge CLK or negedge RESETn_local) begin
        if (!RESETn_local) begin
            CLR_EXT_INT <= 1'b0;
            INT_TIMEOUT <= 1'b0;
        end else begin
            CLR_EXT_INT <= (state == MBUS_EIS_CLEAR);
            INT_TIMEOUT <= INT_TIMEOUT | (state == MBUS_EIS_ERROR);
        end
    end

    assign BC_WAKE_REQ = (state == MBUS_EIS_WAKE);
    assign ARB_REQ     = (state == MBUS_EIS_ARB);

endmodule
